zero_count_pattern_gen: RTL and testbench
=========================================

// Module: zero_count_pattern_gen
// PURPOSE
//   Inverse of the 3-bit zero-count adder. Takes a requested count k. Emits, in ascending
//   numeric order, every WIDTH-bit pattern containing exactly k zeros (or k ones, selectable).
//   Output is a valid/ready stream. Feeds the zero-counter datapath and its self-checking
//   benches with exhaustive, count-targeted stimulus.
// PARAMETERS
//   WIDTH        3  pattern width in bits; legal range 2..8
//   COUNT_ZEROS  1  1: k counts zero bits; 0: k counts one bits
//   (local) CW = $clog2(WIDTH+1), the width of req_count
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req_valid  in   1      request strobe
//   req_ready  out  1      block idle, able to accept a request
//   req_count  in   CW     requested count k
//   pat_valid  out  1      pat_data/pat_last are valid
//   pat_ready  in   1      consumer accepts the pattern
//   pat_data   out  WIDTH  generated pattern
//   pat_last   out  1      final pattern of the current request
//   req_err    out  1      one-cycle pulse: illegal request (k > WIDTH)
//   busy       out  1      request in progress (state != IDLE)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE, cand=0, req_ready=1.
//     - pat_valid=0, pat_data=0, pat_last=0, req_err=0, busy=0.
//   FSM states: IDLE, SCAN, DRAIN.
//   IDLE:
//     - req_ready=1.
//     - On req_valid&req_ready: latch k.
//     - If k>WIDTH: req_err=1 for exactly one cycle, stay IDLE, emit nothing.
//     - Else: cand<=0, go to SCAN.
//   SCAN (one candidate per cycle, cand counts 0..2^WIDTH-1):
//     - match = (popcount of cand's ones, or zeros when COUNT_ZEROS=1) == k.
//     - Output register free = !pat_valid | pat_ready.
//     - match & free: pat_data<=cand, pat_valid<=1, pat_last<=(cand==LASTPAT), cand<=cand+1.
//       If cand==LASTPAT, go to DRAIN.
//     - match & !free: hold cand. pat_* stay stable (no change while valid & !ready).
//     - !match: cand<=cand+1. pat_valid<=0 if the held beat is consumed this cycle.
//   LASTPAT is the largest matching value: the n ones packed in the MSBs, where n = k
//   (ones mode) or WIDTH-k (zeros mode). Example: WIDTH=3, zeros mode, k=1 -> 3'b110.
//   DRAIN: on pat_valid&pat_ready -> pat_valid<=0, pat_last<=0, state<=IDLE.
//     req_ready returns the next cycle.
//   Timing and counts:
//     - First beat is valid 1+m cycles after the accept edge; m = numeric value of the
//       first matching pattern.
//     - Beats per request = C(WIDTH,k).
//     - Worst case, pat_ready held 1: 2^WIDTH+1 cycles request-to-idle.
//   req_valid is ignored while busy. No queueing.
//   cand never wraps: LASTPAT always terminates the scan before 2^WIDTH-1 overflows.
//   pat_ready asserted with pat_valid=0 has no effect.
//   Reset mid-request: everything clears immediately. The partial sequence is abandoned.
//   The next request restarts from cand=0.
// TESTING (WIDTH=3, COUNT_ZEROS=1 unless noted)
//   1. k=3, pat_ready=1 -> one beat 000 with pat_last=1, valid 1 cycle after accept.
//      req_ready=1 two cycles after accept.
//   2. k=1, pat_ready=1 -> beats 011, 101, 110 in order, pat_last only on 110.
//      busy deasserts after the 110 handshake.
//   3. k=2, pat_ready=0 for 5 cycles after the first valid -> 001 held stable and valid
//      throughout. Then 001, 010, 100 with no loss or duplication.
//   4. k=4 -> req_err high exactly 1 cycle. pat_valid never rises. req_ready stays 1.
//   5. rst_n low after the first beat of k=1 -> pat_valid=0 and busy=0 asynchronously.
//      After release, a k=1 request yields 011 first.
//   6. COUNT_ZEROS=0, WIDTH=4, each k=0..4 -> beat counts 1,4,6,4,1.
//      Every pat_data checked against a popcount model, and WIDTH=3 beats through the
//      zero-count adder.

Source files
------------

// File: rtl/zero_count_pattern_gen.sv
// Emits, in ascending order, every WIDTH-bit pattern holding exactly k zeros
// (or k ones) as a valid/ready stream, one candidate value examined per cycle.
module zero_count_pattern_gen #(
    parameter int unsigned WIDTH       = 3,
    parameter bit          COUNT_ZEROS = 1'b1,
    localparam int unsigned CW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CW-1:0]    req_count,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic [WIDTH-1:0] pat_data,
    output logic             pat_last,
    output logic             req_err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] last_pat;
    logic [CW-1:0]    k_q;
    logic [CW-1:0]    ones_cnt;
    logic [CW-1:0]    match_cnt;
    logic [CW-1:0]    n_ones;
    logic             match;
    logic             free_slot;

    // last_pat: the n ones of a matching pattern packed into the MSBs
    always_comb begin
        ones_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones_cnt = ones_cnt + CW'(cand[i]);
        end
        match_cnt = COUNT_ZEROS ? CW'(WIDTH) - ones_cnt : ones_cnt;
        n_ones    = COUNT_ZEROS ? CW'(WIDTH) - k_q : k_q;
        last_pat  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            last_pat[i] = (i + 32'(n_ones)) >= WIDTH;
        end
        match     = (match_cnt == k_q);
        free_slot = !pat_valid || pat_ready;
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            k_q       <= '0;
            pat_valid <= 1'b0;
            pat_data  <= '0;
            pat_last  <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            req_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_count > CW'(WIDTH)) begin
                            req_err <= 1'b1;
                        end else begin
                            k_q   <= req_count;
                            cand  <= '0;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (match) begin
                        if (free_slot) begin
                            pat_data  <= cand;
                            pat_valid <= 1'b1;
                            pat_last  <= (cand == last_pat);
                            // stop at the final match so cand never wraps
                            if (cand == last_pat) begin
                                state <= DRAIN;
                            end else begin
                                cand <= cand + WIDTH'(1);
                            end
                        end
                    end else begin
                        cand <= cand + WIDTH'(1);
                        if (pat_ready) begin
                            pat_valid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (pat_ready) begin
                        pat_valid <= 1'b0;
                        pat_last  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zero_count_pattern_gen.sv
// Directed bench: a WIDTH=3 zeros-mode instance and a WIDTH=4 ones-mode instance.
module tb_zero_count_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       z_req_valid, z_req_ready, z_pat_valid, z_pat_ready;
    logic       z_pat_last, z_req_err, z_busy;
    logic [1:0] z_req_count;
    logic [2:0] z_pat_data;

    logic       o_req_valid, o_req_ready, o_pat_valid, o_pat_ready;
    logic       o_pat_last, o_req_err, o_busy;
    logic [2:0] o_req_count;
    logic [3:0] o_pat_data;

    zero_count_pattern_gen #(.WIDTH(3), .COUNT_ZEROS(1'b1)) u_z3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_count(z_req_count),
        .pat_valid(z_pat_valid), .pat_ready(z_pat_ready), .pat_data(z_pat_data),
        .pat_last(z_pat_last), .req_err(z_req_err), .busy(z_busy)
    );

    zero_count_pattern_gen #(.WIDTH(4), .COUNT_ZEROS(1'b0)) u_o4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(o_req_valid), .req_ready(o_req_ready), .req_count(o_req_count),
        .pat_valid(o_pat_valid), .pat_ready(o_pat_ready), .pat_data(o_pat_data),
        .pat_last(o_pat_last), .req_err(o_req_err), .busy(o_busy)
    );

    int checks = 0;
    int errors = 0;

    int         col_n;
    int         col_first;
    logic [7:0] col_beat[16];
    logic       col_last[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Beats are counted once per valid sample, so pat_ready must be held high.
    task automatic z_collect(input int budget);
        col_n     = 0;
        col_first = -1;
        for (int c = 0; c < budget; c++) begin
            if (z_pat_valid) begin
                if (col_n < 16) begin
                    col_beat[col_n] = 8'(z_pat_data);
                    col_last[col_n] = z_pat_last;
                end
                if (col_first < 0) col_first = c;
                col_n++;
            end
            if (!z_busy) break;
            step();
        end
        check("z_idle_timeout", 32'(z_busy), 32'd0);
    endtask

    task automatic o_collect(input int budget);
        col_n     = 0;
        col_first = -1;
        for (int c = 0; c < budget; c++) begin
            if (o_pat_valid) begin
                if (col_n < 16) begin
                    col_beat[col_n] = 8'(o_pat_data);
                    col_last[col_n] = o_pat_last;
                end
                if (col_first < 0) col_first = c;
                col_n++;
            end
            if (!o_busy) break;
            step();
        end
        check("o_idle_timeout", 32'(o_busy), 32'd0);
    endtask

    task automatic check_stream(input string tag, input int w, input bit zeros,
                                input int k, input bit chk_lat);
        int         exp_n;
        int         cnt;
        logic [7:0] exp_v[16];
        exp_n = 0;
        for (int v = 0; v < (1 << w); v++) begin
            cnt = zeros ? w - $countones(v) : $countones(v);
            if (cnt == k) begin
                exp_v[exp_n] = 8'(v);
                exp_n++;
            end
        end
        check({tag, "_count"}, 32'(col_n), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            if (i < col_n) begin
                check($sformatf("%s_data%0d", tag, i), 32'(col_beat[i]), 32'(exp_v[i]));
                check($sformatf("%s_last%0d", tag, i), 32'(col_last[i]), 32'(i == exp_n - 1));
            end
        end
        if (chk_lat) check({tag, "_latency"}, 32'(col_first), 32'(1 + exp_v[0]));
    endtask

    int binom4[5] = '{1, 4, 6, 4, 1};

    initial begin
        rst_n       = 1'b1;
        z_req_valid = 1'b0; z_req_count = '0; z_pat_ready = 1'b0;
        o_req_valid = 1'b0; o_req_count = '0; o_pat_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_req_ready", 32'(z_req_ready), 32'd1);
        check("rst_pat_valid", 32'(z_pat_valid), 32'd0);
        check("rst_pat_data",  32'(z_pat_data),  32'd0);
        check("rst_pat_last",  32'(z_pat_last),  32'd0);
        check("rst_req_err",   32'(z_req_err),   32'd0);
        check("rst_busy",      32'(z_busy),      32'd0);
        check("rst_o_busy",    32'(o_busy),      32'd0);
        #9 rst_n = 1'b1;
        step();

        // k=3: single all-zero beat, one cycle after accept
        z_pat_ready = 1'b1;
        z_req_count = 2'd3;
        z_req_valid = 1'b1;
        step();
        z_req_valid = 1'b0;
        check("t1_busy",       32'(z_busy),      32'd1);
        check("t1_req_ready0", 32'(z_req_ready), 32'd0);
        check("t1_valid0",     32'(z_pat_valid), 32'd0);
        step();
        check("t1_valid",      32'(z_pat_valid), 32'd1);
        check("t1_data",       32'(z_pat_data),  32'd0);
        check("t1_last",       32'(z_pat_last),  32'd1);
        step();
        check("t1_valid_off",  32'(z_pat_valid), 32'd0);
        check("t1_busy_off",   32'(z_busy),      32'd0);
        check("t1_req_ready",  32'(z_req_ready), 32'd1);

        // k=1: 011, 101, 110
        z_req_count = 2'd1;
        z_req_valid = 1'b1;
        step();
        z_req_valid = 1'b0;
        z_collect(20);
        check_stream("t2", 3, 1'b1, 1, 1'b1);
        check("t2_beat0", 32'(col_beat[0]), 32'b011);
        check("t2_beat2", 32'(col_beat[2]), 32'b110);
        check("t2_req_ready", 32'(z_req_ready), 32'd1);

        // k=2 with backpressure: 001 must hold for 5 stalled cycles
        z_pat_ready = 1'b0;
        z_req_count = 2'd2;
        z_req_valid = 1'b1;
        step();
        z_req_valid = 1'b0;
        step();
        step();
        check("t3_valid", 32'(z_pat_valid), 32'd1);
        check("t3_data",  32'(z_pat_data),  32'b001);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("t3_hold_valid%0d", c), 32'(z_pat_valid), 32'd1);
            check($sformatf("t3_hold_data%0d", c),  32'(z_pat_data),  32'b001);
            check($sformatf("t3_hold_last%0d", c),  32'(z_pat_last),  32'd0);
        end
        z_pat_ready = 1'b1;
        z_collect(20);
        check_stream("t3", 3, 1'b1, 2, 1'b0);

        // asynchronous reset after the first beat of k=1
        z_req_count = 2'd1;
        z_req_valid = 1'b1;
        step();
        z_req_valid = 1'b0;
        for (int c = 0; c < 10 && !z_pat_valid; c++) step();
        check("t5_first_valid", 32'(z_pat_valid), 32'd1);
        check("t5_first_data",  32'(z_pat_data),  32'b011);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid",     32'(z_pat_valid), 32'd0);
        check("t5_rst_busy",      32'(z_busy),      32'd0);
        check("t5_rst_req_ready", 32'(z_req_ready), 32'd1);
        #2 rst_n = 1'b1;
        step();
        z_req_valid = 1'b1;
        step();
        z_req_valid = 1'b0;
        z_collect(20);
        check_stream("t5", 3, 1'b1, 1, 1'b1);

        // zeros mode, every legal k at WIDTH=3 (k=0 is the full 2^3+1 scan)
        for (int k = 0; k <= 3; k++) begin
            z_req_count = 2'(k);
            z_req_valid = 1'b1;
            step();
            z_req_valid = 1'b0;
            z_collect(20);
            check_stream($sformatf("z3_k%0d", k), 3, 1'b1, k, 1'b1);
        end

        // illegal k (k=4 is not encodable at WIDTH=3, so use WIDTH=4)
        o_pat_ready = 1'b1;
        o_req_count = 3'd5;
        o_req_valid = 1'b1;
        step();
        o_req_valid = 1'b0;
        check("t4_err",       32'(o_req_err),   32'd1);
        check("t4_req_ready", 32'(o_req_ready), 32'd1);
        check("t4_busy",      32'(o_busy),      32'd0);
        check("t4_valid",     32'(o_pat_valid), 32'd0);
        step();
        check("t4_err_off",   32'(o_req_err),   32'd0);
        step();
        check("t4_err_off2",  32'(o_req_err),   32'd0);
        check("t4_valid2",    32'(o_pat_valid), 32'd0);
        check("t4_busy2",     32'(o_busy),      32'd0);

        // ones mode, WIDTH=4, every k
        for (int k = 0; k <= 4; k++) begin
            o_req_count = 3'(k);
            o_req_valid = 1'b1;
            step();
            o_req_valid = 1'b0;
            o_collect(30);
            check($sformatf("t6_k%0d_binom", k), 32'(col_n), 32'(binom4[k]));
            check_stream($sformatf("t6_k%0d", k), 4, 1'b0, k, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
